// File: rtl/m92_sound_bus.sv
// rtl/m92_sound_bus.sv - M92 V35 sound CPU memory-bus back end and clock-enable generator
//
// Ports:
//   clk, reset                       system clock, synchronous active-high reset
//   ce, ce_cycle                     V35 4x enable and internal-clock enable
//   mem_rd, mem_wr, mem_be,
//   mem_addr, mem_dout, mem_din      V35 external bus
//   rom_addr, rom_req, rom_ack,
//   rom_data                         SDRAM sound ROM, toggle handshake
//   ym_cs, ym_wr, ym_a0, ym_din,
//   ym_dout                          YM2151
//   ga20_wr, ga20_rd, ga20_addr,
//   ga20_din, ga20_dout              GA20
//   latch_wr, latch_din, snd_intp_n  main-to-sound latch and its interrupt
//   reply_dout, reply_irq, reply_ack sound-to-main reply latch
module m92_sound_bus #(
    parameter int CE_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ce,
    output logic        ce_cycle,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  mem_be,
    input  logic [19:0] mem_addr,
    input  logic [15:0] mem_dout,
    output logic [15:0] mem_din,
    output logic [18:0] rom_addr,
    output logic        rom_req,
    input  logic        rom_ack,
    input  logic [15:0] rom_data,
    output logic        ym_cs,
    output logic        ym_wr,
    output logic        ym_a0,
    output logic [7:0]  ym_din,
    input  logic [7:0]  ym_dout,
    output logic        ga20_wr,
    output logic        ga20_rd,
    output logic [4:0]  ga20_addr,
    output logic [7:0]  ga20_din,
    input  logic [7:0]  ga20_dout,
    input  logic        latch_wr,
    input  logic [7:0]  latch_din,
    output logic        snd_intp_n,
    output logic [7:0]  reply_dout,
    output logic        reply_irq,
    input  logic        reply_ack
);

    localparam int DIV_W = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [DIV_W-1:0] div;
    logic [1:0]       phase;
    logic [0:0]       state;
    logic             stall;
    logic             pending;
    logic [7:0]       latch;

    // The CPU is frozen for the whole WAIT state, including the ack clock,
    // so the data it sees on its next enable is always the fetched word.
    assign stall      = (state == ST_WAIT);
    assign ce         = (div == DIV_LAST) & ~stall;
    assign ce_cycle   = ce & (phase == 2'd3);
    assign snd_intp_n = ~pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            div   <= '0;
            phase <= 2'd0;
        end else if (!stall) begin
            if (div == DIV_LAST) begin
                div   <= '0;
                phase <= phase + 2'd1;
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

    // Bus accesses are only accepted while no ROM fetch is in flight; a
    // simultaneous read and write is treated as a write so that a single
    // bus clock never yields more than one device strobe.
    logic        bus_wr, bus_rd;
    logic        hit_rom, hit_ram, hit_ga20, hit_ym, hit_latch, hit_reply;
    logic [12:0] ram_word;

    assign bus_wr    = mem_wr & (state == ST_IDLE);
    assign bus_rd    = mem_rd & ~mem_wr & (state == ST_IDLE);
    assign hit_rom   = (mem_addr < 20'h20000);
    assign hit_ram   = (mem_addr >= 20'hA0000) && (mem_addr <= 20'hA3FFF);
    assign hit_ga20  = (mem_addr >= 20'hA8000) && (mem_addr <= 20'hA803F);
    assign hit_ym    = (mem_addr >= 20'hA8040) && (mem_addr <= 20'hA8043);
    assign hit_latch = (mem_addr[19:1] == 19'h54022);
    assign hit_reply = (mem_addr[19:1] == 19'h54023);
    assign ram_word  = mem_addr[13:1];

    logic [7:0] ram_lo [0:8191];
    logic [7:0] ram_hi [0:8191];

    always_ff @(posedge clk) begin
        if (bus_wr && hit_ram) begin
            if (mem_be[0]) ram_lo[ram_word] <= mem_dout[7:0];
            if (mem_be[1]) ram_hi[ram_word] <= mem_dout[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rom_addr   <= '0;
            rom_req    <= 1'b0;
            mem_din    <= 16'h0000;
            ym_cs      <= 1'b0;
            ym_wr      <= 1'b0;
            ym_a0      <= 1'b0;
            ym_din     <= 8'h00;
            ga20_wr    <= 1'b0;
            ga20_rd    <= 1'b0;
            ga20_addr  <= 5'd0;
            ga20_din   <= 8'h00;
            latch      <= 8'h00;
            pending    <= 1'b0;
            reply_dout <= 8'h00;
            reply_irq  <= 1'b0;
        end else begin
            ym_cs   <= 1'b0;
            ym_wr   <= 1'b0;
            ga20_wr <= 1'b0;
            ga20_rd <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus_rd && hit_rom) begin
                        rom_addr <= mem_addr[19:1];
                        rom_req  <= ~rom_req;
                        state    <= ST_WAIT;
                    end
                end
                default: begin
                    if (rom_ack == rom_req) begin
                        mem_din <= rom_data;
                        state   <= ST_IDLE;
                    end
                end
            endcase

            if (bus_rd && !hit_rom) begin
                if (hit_ram) begin
                    mem_din <= {ram_hi[ram_word], ram_lo[ram_word]};
                end else if (hit_ga20) begin
                    mem_din   <= {ga20_dout, ga20_dout};
                    ga20_rd   <= 1'b1;
                    ga20_addr <= mem_addr[5:1];
                end else if (hit_ym) begin
                    mem_din <= {ym_dout, ym_dout};
                    ym_cs   <= 1'b1;
                    ym_a0   <= mem_addr[1];
                end else if (hit_latch) begin
                    mem_din <= {latch, latch};
                end else begin
                    mem_din <= 16'hFFFF;
                end
            end

            if (bus_wr) begin
                if (hit_ga20) begin
                    ga20_wr   <= 1'b1;
                    ga20_addr <= mem_addr[5:1];
                    ga20_din  <= mem_dout[7:0];
                end else if (hit_ym) begin
                    ym_cs  <= 1'b1;
                    ym_wr  <= 1'b1;
                    ym_a0  <= mem_addr[1];
                    ym_din <= mem_dout[7:0];
                end
            end

            // A new main-CPU command must never be lost to a stale ack.
            if (latch_wr) begin
                latch   <= latch_din;
                pending <= 1'b1;
            end else if (bus_wr && hit_latch) begin
                pending <= 1'b0;
            end

            // A fresh reply wins over the main CPU's ack of the previous one.
            if (bus_wr && hit_reply) begin
                reply_dout <= mem_dout[7:0];
                reply_irq  <= 1'b1;
            end else if (reply_ack) begin
                reply_irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_m92_sound_bus.sv
// tb/tb_m92_sound_bus.sv - directed self-checking bench for m92_sound_bus
module tb_m92_sound_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce, ce_cycle;
    logic        mem_rd, mem_wr;
    logic [1:0]  mem_be;
    logic [19:0] mem_addr;
    logic [15:0] mem_dout, mem_din;
    logic [18:0] rom_addr;
    logic        rom_req, rom_ack;
    logic [15:0] rom_data;
    logic        ym_cs, ym_wr, ym_a0;
    logic [7:0]  ym_din, ym_dout;
    logic        ga20_wr, ga20_rd;
    logic [4:0]  ga20_addr;
    logic [7:0]  ga20_din, ga20_dout;
    logic        latch_wr;
    logic [7:0]  latch_din;
    logic        snd_intp_n;
    logic [7:0]  reply_dout;
    logic        reply_irq, reply_ack;

    int checks = 0;
    int errors = 0;

    m92_sound_bus #(.CE_DIV(2)) dut (
        .clk(clk), .reset(reset), .ce(ce), .ce_cycle(ce_cycle),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .mem_din(mem_din),
        .rom_addr(rom_addr), .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data),
        .ym_cs(ym_cs), .ym_wr(ym_wr), .ym_a0(ym_a0), .ym_din(ym_din), .ym_dout(ym_dout),
        .ga20_wr(ga20_wr), .ga20_rd(ga20_rd), .ga20_addr(ga20_addr),
        .ga20_din(ga20_din), .ga20_dout(ga20_dout),
        .latch_wr(latch_wr), .latch_din(latch_din), .snd_intp_n(snd_intp_n),
        .reply_dout(reply_dout), .reply_irq(reply_irq), .reply_ack(reply_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; mem_be = 2'b11;
        mem_addr = 20'h0; mem_dout = 16'h0; rom_ack = 1'b0; rom_data = 16'h0;
        ym_dout = 8'h00; ga20_dout = 8'h00; latch_wr = 1'b0; latch_din = 8'h00;
        reply_ack = 1'b0;
        repeat (3) step();

        check("rst_ce", 32'(ce), 32'd0);
        check("rst_ce_cycle", 32'(ce_cycle), 32'd0);
        check("rst_mem_din", 32'(mem_din), 32'h0);
        check("rst_rom_req", 32'(rom_req), 32'd0);
        check("rst_intp_n", 32'(snd_intp_n), 32'd1);
        check("rst_reply_irq", 32'(reply_irq), 32'd0);
        check("rst_reply_dout", 32'(reply_dout), 32'h0);
        check("rst_ym_cs", 32'(ym_cs), 32'd0);
        check("rst_ga20_wr", 32'(ga20_wr), 32'd0);

        // Free run: ce consumed on every 2nd clk from clk 2, ce_cycle on the 4th ce.
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("free_ce_%0d", k), 32'(ce), 32'((k % 2) == 1));
            check($sformatf("free_cc_%0d", k), 32'(ce_cycle), 32'(k == 7));
        end

        // ROM read at 01234, ack after several clks.
        mem_rd = 1'b1; mem_addr = 20'h01234;
        step();
        mem_rd = 1'b0;
        check("rom_addr", 32'(rom_addr), 32'h091A);
        check("rom_req_toggle", 32'(rom_req), 32'd1);
        check("rom_wait_ce0", 32'(ce), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("rom_stall_ce_%0d", k), 32'(ce), 32'd0);
        end
        rom_data = 16'hBEEF; rom_ack = 1'b1;
        step();
        check("rom_data", 32'(mem_din), 32'hBEEF);
        check("rom_req_once", 32'(rom_req), 32'd1);
        for (int s = 0; s <= 6; s++) begin
            if (s > 0) step();
            check($sformatf("resume_ce_%0d", s), 32'(ce), 32'((s % 2) == 0));
            check($sformatf("resume_cc_%0d", s), 32'(ce_cycle), 32'(s == 6));
        end
        step();

        // RAM byte-enable write over a preloaded word.
        mem_wr = 1'b1; mem_addr = 20'hA0010; mem_be = 2'b11; mem_dout = 16'h12FF;
        step();
        mem_be = 2'b10; mem_dout = 16'h55AA;
        step();
        mem_wr = 1'b0; mem_be = 2'b11; mem_rd = 1'b1;
        step();
        mem_rd = 1'b0;
        check("ram_be_read", 32'(mem_din), 32'h55FF);

        // Sound latch.
        latch_wr = 1'b1; latch_din = 8'h3C;
        step();
        latch_wr = 1'b0;
        check("latch_intp_low", 32'(snd_intp_n), 32'd0);
        mem_rd = 1'b1; mem_addr = 20'hA8044;
        step();
        mem_rd = 1'b0;
        check("latch_read", 32'(mem_din), 32'h3C3C);
        mem_wr = 1'b1; mem_dout = 16'h0000;
        step();
        mem_wr = 1'b0;
        check("latch_ack_high", 32'(snd_intp_n), 32'd1);
        mem_wr = 1'b1; latch_wr = 1'b1; latch_din = 8'h5A;
        step();
        mem_wr = 1'b0; latch_wr = 1'b0;
        check("latch_race_low", 32'(snd_intp_n), 32'd0);
        mem_rd = 1'b1;
        step();
        mem_rd = 1'b0;
        check("latch_race_data", 32'(mem_din), 32'h5A5A);

        // YM2151 write, read, and an unmapped read.
        mem_wr = 1'b1; mem_addr = 20'hA8042; mem_dout = 16'h0028;
        check("ym_pre", 32'(ym_cs), 32'd0);
        step();
        mem_wr = 1'b0;
        check("ym_wr_strobe", {29'd0, ym_cs, ym_wr, ym_a0}, 32'h7);
        check("ym_din", 32'(ym_din), 32'h28);
        step();
        check("ym_single_pulse", {30'd0, ym_cs, ym_wr}, 32'h0);
        ym_dout = 8'h81; mem_rd = 1'b1; mem_addr = 20'hA8041;
        step();
        mem_rd = 1'b0;
        check("ym_read", 32'(mem_din), 32'h8181);
        check("ym_rd_strobe", {29'd0, ym_cs, ym_wr, ym_a0}, 32'h4);
        mem_rd = 1'b1; mem_addr = 20'hA8050;
        step();
        mem_rd = 1'b0;
        check("unmapped_read", 32'(mem_din), 32'hFFFF);

        // GA20 write.
        mem_wr = 1'b1; mem_addr = 20'hA8006; mem_dout = 16'h0042;
        step();
        mem_wr = 1'b0;
        check("ga20_wr", 32'(ga20_wr), 32'd1);
        check("ga20_addr", 32'(ga20_addr), 32'd3);
        check("ga20_din", 32'(ga20_din), 32'h42);

        // Reply latch.
        mem_wr = 1'b1; mem_addr = 20'hA8046; mem_dout = 16'h00C3;
        step();
        check("reply_set", {23'd0, reply_irq, reply_dout}, 32'h1C3);
        mem_dout = 16'h0011; reply_ack = 1'b1;
        step();
        mem_wr = 1'b0;
        check("reply_race", {23'd0, reply_irq, reply_dout}, 32'h111);
        step();
        reply_ack = 1'b0;
        check("reply_ack", 32'(reply_irq), 32'd0);

        // ROM read at top of ROM with the ack already matching: one WAIT clk.
        mem_rd = 1'b1; mem_addr = 20'h1FFFE; rom_data = 16'h1357;
        step();
        mem_rd = 1'b0; rom_ack = 1'b0;
        check("rom_top_addr", 32'(rom_addr), 32'h0FFFF);
        check("rom_top_req", 32'(rom_req), 32'd0);
        step();
        check("rom_fast_data", 32'(mem_din), 32'h1357);

        // ROM write is ignored.
        mem_wr = 1'b1; mem_addr = 20'h00010; mem_dout = 16'h1111;
        step();
        mem_wr = 1'b0;
        check("rom_write_ignored", 32'(rom_req), 32'd0);

        // Reset in the middle of a fetch.
        mem_wr = 1'b1; mem_addr = 20'hA8046; mem_dout = 16'h0099;
        step();
        mem_wr = 1'b0;
        mem_rd = 1'b1; mem_addr = 20'h00100;
        step();
        mem_rd = 1'b0;
        check("mid_req", 32'(rom_req), 32'd1);
        step();
        reset = 1'b1;
        step();
        check("mid_rst_req", 32'(rom_req), 32'd0);
        check("mid_rst_irq", 32'(reply_irq), 32'd0);
        check("mid_rst_ce", 32'(ce), 32'd0);
        reset = 1'b0;
        step();
        check("restart_ce_1", 32'(ce), 32'd1);
        step();
        check("restart_ce_2", 32'(ce), 32'd0);
        step();
        check("restart_ce_3", 32'(ce), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
